// File: rtl/dsp_operand_skid.sv
// Two-entry valid/ready skid buffer feeding 48-bit DSP logic ports (C = a, A:B = b).
// Optional head-entry parity output is enabled by defining DSP_OPERAND_PARITY_EN.
module dsp_operand_skid #(
    parameter int width    = 48,
    parameter int sign_ext = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [width-1:0] in_a,
    input  logic [width-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [29:0]      dsp_a,
    output logic [17:0]      dsp_b,
    output logic [47:0]      dsp_c,
`ifdef DSP_OPERAND_PARITY_EN
    output logic             out_parity,
`endif
    output logic [1:0]       occupancy
);

    generate
        if (width < 1 || width > 48) begin : g_bad_width
            $error("dsp_operand_skid: width must be within 1..48");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    typedef struct packed {
        logic [47:0] c;
        logic [47:0] b;
`ifdef DSP_OPERAND_PARITY_EN
        logic        p;
`endif
    } entry_t;

    function automatic logic [47:0] ext48(input logic [width-1:0] x);
        logic [47:0] r;
        r = (sign_ext != 0) ? {48{x[width-1]}} : 48'd0;
        r[width-1:0] = x;
        return r;
    endfunction

    function automatic logic parity48(input logic [47:0] c, input logic [47:0] b);
        return ^(c ^ b);
    endfunction

    function automatic entry_t make_entry(input logic [width-1:0] a, input logic [width-1:0] b);
        entry_t e;
        e.c = ext48(a);
        e.b = ext48(b);
`ifdef DSP_OPERAND_PARITY_EN
        e.p = parity48(e.c, e.b);
`endif
        return e;
    endfunction

    state_t      state_q, state_d;
    entry_t      head_q, head_d;
    entry_t      skid_q, skid_d;
    logic        out_valid_q, out_valid_d;
    logic        in_ready_q, in_ready_d;
    logic [1:0]  occupancy_q, occupancy_d;
    logic        push_s;
    logic        pop_s;
    entry_t      new_s;

    assign push_s = in_valid & in_ready_q;
    assign pop_s  = out_valid_q & out_ready;
    assign new_s  = make_entry(in_a, in_b);

    // Next-state and entry movement; status flags derive from the next state so they are registered.
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        case (state_q)
            ST_EMPTY: begin
                if (push_s) begin
                    head_d  = new_s;
                    state_d = ST_ONE;
                end else begin
                    state_d = ST_EMPTY;
                end
            end
            ST_ONE: begin
                if (push_s && pop_s) begin
                    head_d  = new_s;
                    state_d = ST_ONE;
                end else if (push_s) begin
                    skid_d  = new_s;
                    state_d = ST_FULL;
                end else if (pop_s) begin
                    state_d = ST_EMPTY;
                end else begin
                    state_d = ST_ONE;
                end
            end
            ST_FULL: begin
                if (pop_s) begin
                    head_d  = skid_q;
                    state_d = ST_ONE;
                end else begin
                    state_d = ST_FULL;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
        out_valid_d = (state_d != ST_EMPTY);
        in_ready_d  = (state_d != ST_FULL);
        occupancy_d = state_d;
    end

    // State and storage registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= ST_EMPTY;
            head_q      <= '0;
            skid_q      <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            occupancy_q <= 2'd0;
        end else begin
            state_q     <= state_d;
            head_q      <= head_d;
            skid_q      <= skid_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            occupancy_q <= occupancy_d;
        end
    end

    assign out_valid = out_valid_q;
    assign in_ready  = in_ready_q;
    assign occupancy = occupancy_q;
    assign dsp_c     = head_q.c;
    assign dsp_a     = head_q.b[47:18];
    assign dsp_b     = head_q.b[17:0];
`ifdef DSP_OPERAND_PARITY_EN
    assign out_parity = head_q.p;
`endif

endmodule

// File: tb/tb_dsp_operand_skid.sv
// Self-checking bench for dsp_operand_skid: vector table, FIFO scoreboard, hand-written corner sequences.
module tb_dsp_operand_skid;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic        out_ready;
    logic [7:0]  in_a, in_b;
    logic        in_ready_m, out_valid_m;
    logic [29:0] dsp_a_m;
    logic [17:0] dsp_b_m;
    logic [47:0] dsp_c_m;
    logic [1:0]  occ_m;
    logic        par_m;

    logic [7:0]  z8_a, z8_b;
    logic        z8_ir, z8_ov;
    logic [29:0] z8_dsp_a;
    logic [17:0] z8_dsp_b;
    logic [47:0] z8_dsp_c;
    logic [1:0]  z8_occ;
    logic        z8_par;

    logic [47:0] w48_a, w48_b;
    logic        w48_ir, w48_ov;
    logic [29:0] w48_dsp_a;
    logic [17:0] w48_dsp_b;
    logic [47:0] w48_dsp_c;
    logic [1:0]  w48_occ;
    logic        w48_par;

    int vectors = 0;
    int miscompares = 0;
    int dut_pops = 0;

    typedef struct {
        logic [47:0] c;
        logic [47:0] b;
        logic        p;
    } sb_entry_t;

    sb_entry_t sb[$];
    bit        cleared = 1'b1;

    typedef struct {
        bit          rst_n;
        bit          vld;
        bit          rdy;
        logic [7:0]  a;
        logic [7:0]  b;
        int          occ;
        bit          ov;
        bit          ir;
        bit          chk;
        logic [47:0] ec;
        logic [47:0] eb;
    } vec_t;

    vec_t tv[9];

    dsp_operand_skid #(.width(8), .sign_ext(1)) u_main (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_m),
        .in_a(in_a), .in_b(in_b), .out_valid(out_valid_m), .out_ready(out_ready),
        .dsp_a(dsp_a_m), .dsp_b(dsp_b_m), .dsp_c(dsp_c_m),
`ifdef DSP_OPERAND_PARITY_EN
        .out_parity(par_m),
`endif
        .occupancy(occ_m)
    );

    dsp_operand_skid #(.width(8), .sign_ext(0)) u_z8 (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(z8_ir),
        .in_a(z8_a), .in_b(z8_b), .out_valid(z8_ov), .out_ready(out_ready),
        .dsp_a(z8_dsp_a), .dsp_b(z8_dsp_b), .dsp_c(z8_dsp_c),
`ifdef DSP_OPERAND_PARITY_EN
        .out_parity(z8_par),
`endif
        .occupancy(z8_occ)
    );

    dsp_operand_skid #(.width(48), .sign_ext(1)) u_w48 (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(w48_ir),
        .in_a(w48_a), .in_b(w48_b), .out_valid(w48_ov), .out_ready(out_ready),
        .dsp_a(w48_dsp_a), .dsp_b(w48_dsp_b), .dsp_c(w48_dsp_c),
`ifdef DSP_OPERAND_PARITY_EN
        .out_parity(w48_par),
`endif
        .occupancy(w48_occ)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [47:0] model_sext8(input logic [7:0] x);
        return {{40{x[7]}}, x};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Compare the DUT against the scoreboard model after an edge.
    task automatic check_sb();
        chk("occupancy", 64'(occ_m), 64'(sb.size()));
        chk("out_valid", 64'(out_valid_m), 64'(sb.size() != 0));
        chk("in_ready", 64'(in_ready_m), 64'(sb.size() != 2));
        if (sb.size() != 0) begin
            chk("head_c", 64'(dsp_c_m), 64'(sb[0].c));
            chk("head_b", 64'({dsp_a_m, dsp_b_m}), 64'(sb[0].b));
`ifdef DSP_OPERAND_PARITY_EN
            chk("head_parity", 64'(par_m), 64'(sb[0].p));
`endif
        end else if (cleared) begin
            chk("cleared_c", 64'(dsp_c_m), 64'd0);
            chk("cleared_b", 64'({dsp_a_m, dsp_b_m}), 64'd0);
`ifdef DSP_OPERAND_PARITY_EN
            chk("cleared_parity", 64'(par_m), 64'd0);
`endif
        end
    endtask

    // Advance one clock, updating the model from the bench's own inputs.
    task automatic tick();
        bit        push_m, pop_m;
        sb_entry_t e;
        push_m = in_valid && (sb.size() != 2);
        pop_m  = (sb.size() != 0) && out_ready;
        e.c = model_sext8(in_a);
        e.b = model_sext8(in_b);
        e.p = ^(e.c ^ e.b);
        if (out_valid_m === 1'b1 && out_ready && reset) dut_pops++;
        @(posedge clock);
        if (!reset) begin
            sb.delete();
            cleared = 1'b1;
        end else begin
            if (pop_m) void'(sb.pop_front());
            if (push_m) begin
                sb.push_back(e);
                cleared = 1'b0;
            end
        end
        #1;
        check_sb();
    endtask

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        in_a      = 8'h85;
        in_b      = 8'h03;
        z8_a      = 8'h85;
        z8_b      = 8'h85;
        w48_a     = 48'hFFFF_0000_1234;
        w48_b     = 48'h8000_0000_0001;

        tv[0] = '{1'b0, 1'b1, 1'b0, 8'h85, 8'h03, 0, 1'b0, 1'b1, 1'b1, 48'h0, 48'h0};
        tv[1] = '{1'b0, 1'b1, 1'b0, 8'h85, 8'h03, 0, 1'b0, 1'b1, 1'b1, 48'h0, 48'h0};
        tv[2] = '{1'b1, 1'b1, 1'b0, 8'h85, 8'h03, 1, 1'b1, 1'b1, 1'b1, 48'hFFFF_FFFF_FF85, 48'h3};
        tv[3] = '{1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 0, 1'b0, 1'b1, 1'b0, 48'h0, 48'h0};
        tv[4] = '{1'b1, 1'b1, 1'b0, 8'h01, 8'h02, 1, 1'b1, 1'b1, 1'b1, 48'h1, 48'h2};
        tv[5] = '{1'b1, 1'b1, 1'b0, 8'h03, 8'h04, 2, 1'b1, 1'b0, 1'b1, 48'h1, 48'h2};
        tv[6] = '{1'b1, 1'b1, 1'b0, 8'h05, 8'h06, 2, 1'b1, 1'b0, 1'b1, 48'h1, 48'h2};
        tv[7] = '{1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 1, 1'b1, 1'b1, 1'b1, 48'h3, 48'h4};
        tv[8] = '{1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 0, 1'b0, 1'b1, 1'b0, 48'h0, 48'h0};

        // Reset, first push, backpressure fill and drain.
        for (int i = 0; i < 9; i++) begin
            reset     = tv[i].rst_n;
            in_valid  = tv[i].vld;
            out_ready = tv[i].rdy;
            in_a      = tv[i].a;
            in_b      = tv[i].b;
            tick();
            chk($sformatf("tv%0d_occ", i), 64'(occ_m), 64'(tv[i].occ));
            chk($sformatf("tv%0d_out_valid", i), 64'(out_valid_m), 64'(tv[i].ov));
            chk($sformatf("tv%0d_in_ready", i), 64'(in_ready_m), 64'(tv[i].ir));
            if (tv[i].chk) begin
                chk($sformatf("tv%0d_dsp_c", i), 64'(dsp_c_m), 64'(tv[i].ec));
                chk($sformatf("tv%0d_dsp_ab", i), 64'({dsp_a_m, dsp_b_m}), 64'(tv[i].eb));
            end
        end
        chk("first_dsp_a_zero_seen", 64'(tv[2].eb[47:18]), 64'(30'd0));

        // Streaming: one pair per cycle, occupancy pinned at 1.
        dut_pops = 0;
        for (int i = 0; i < 10; i++) begin
            in_valid  = 1'b1;
            out_ready = 1'b1;
            in_a      = 8'h10 + 8'(i);
            in_b      = 8'h70 + 8'(i);
            tick();
            chk($sformatf("stream%0d_occ", i), 64'(occ_m), 64'd1);
            chk($sformatf("stream%0d_c", i), 64'(dsp_c_m), 64'(48'h10 + 48'(i)));
        end
        in_valid = 1'b0;
        tick();
        chk("stream_pop_count", 64'(dut_pops), 64'd10);

        // Reset while FULL discards both entries.
        in_valid  = 1'b1;
        out_ready = 1'b0;
        in_a = 8'h31; in_b = 8'h32;
        tick();
        in_a = 8'h33; in_b = 8'h34;
        tick();
        chk("full_before_reset", 64'(occ_m), 64'd2);
        reset    = 1'b0;
        in_valid = 1'b0;
        tick();
        chk("reset_full_occ", 64'(occ_m), 64'd0);
        chk("reset_full_ov", 64'(out_valid_m), 64'd0);
        reset    = 1'b1;
        in_valid = 1'b1;
        in_a = 8'h0F; in_b = 8'h01;
        tick();
        chk("post_reset_head_c", 64'(dsp_c_m), 64'h0F);
        chk("post_reset_head_b", 64'({dsp_a_m, dsp_b_m}), 64'h01);
`ifdef DSP_OPERAND_PARITY_EN
        chk("parity_0f_01", 64'(par_m), 64'd1);
`endif
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("post_reset_drained", 64'(occ_m), 64'd0);

        // Zero extension and full-width split on the side instances.
        reset = 1'b0;
        tick();
        reset     = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        tick();
        chk("z8_dsp_c", 64'(z8_dsp_c), 64'h85);
        chk("z8_dsp_ab", 64'({z8_dsp_a, z8_dsp_b}), 64'h85);
        chk("w48_dsp_a", 64'(w48_dsp_a), 64'(30'h2000_0000));
        chk("w48_dsp_b", 64'(w48_dsp_b), 64'(18'h00001));
        chk("w48_dsp_c", 64'(w48_dsp_c), 64'hFFFF_0000_1234);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
